// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller.
// State encoding, forwarding selects and push-word selects.
package pipe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_CCR,
        S_VECTOR
    } seq_state_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        PW_NONE,
        PW_PC_HI,
        PW_PC_LO,
        PW_CCR
    } push_sel_e;

endpackage

// File: rtl/pipe_ctrl_unit_int_sequencer.sv
// Interrupt sequencer: drains the pipe, pushes PC/CCR, redirects.
// Owns the edge detector, pending flag and saved context.
module int_sequencer
    import pipe_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 32,
    parameter int CCR_W        = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic              int_req_i,
    input  logic [ADDR_W-1:0] dec_pc_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic [CCR_W-1:0]  ccr_i,
    output logic              seq_hold_o,
    output logic              seq_bubble_o,
    output logic              seq_flush_fd_o,
    output logic              int_push_o,
    output logic [DATA_W-1:0] push_data_o,
    output logic              int_load_pc_o,
    output logic              int_ack_o,
    output logic              int_active_o
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              int_req_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CCR_W-1:0]  ccr_q, ccr_d;
    push_sel_e         push_sel;
    logic              int_edge;

    assign int_edge     = int_req_i & ~int_req_q;
    assign int_active_o = (state_q != S_IDLE);

    // State, counter, edge history and saved context registers.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            int_req_q <= 1'b0;
            pc_q      <= '0;
            ccr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            int_req_q <= int_req_i;
            pc_q      <= pc_d;
            ccr_q     <= ccr_d;
        end
    end

    // Next-state and sequencer control outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        pc_d           = pc_q;
        ccr_d          = ccr_q;
        seq_hold_o     = 1'b0;
        seq_bubble_o   = 1'b0;
        seq_flush_fd_o = 1'b0;
        int_push_o     = 1'b0;
        int_load_pc_o  = 1'b0;
        int_ack_o      = 1'b0;
        push_sel       = PW_NONE;
        if (int_edge && state_q != S_IDLE) pend_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (int_edge || pend_q) begin
                    state_d        = S_DRAIN;
                    cnt_d          = CNT_LOAD;
                    pend_d         = 1'b0;
                    pc_d           = br_taken_i ? br_target_i : dec_pc_i;
                    seq_flush_fd_o = 1'b1;
                end
            end
            S_DRAIN: begin
                seq_hold_o   = 1'b1;
                seq_bubble_o = 1'b1;
                if (br_taken_i) pc_d = br_target_i;
                if (cnt_q == '0) begin
                    ccr_d   = ccr_i;
                    state_d = S_PUSH_HI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PUSH_HI: begin
                seq_hold_o   = 1'b1;
                seq_bubble_o = 1'b1;
                int_push_o   = 1'b1;
                push_sel     = PW_PC_HI;
                state_d      = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                seq_hold_o   = 1'b1;
                seq_bubble_o = 1'b1;
                int_push_o   = 1'b1;
                push_sel     = PW_PC_LO;
                state_d      = S_PUSH_CCR;
            end
            S_PUSH_CCR: begin
                seq_hold_o   = 1'b1;
                seq_bubble_o = 1'b1;
                int_push_o   = 1'b1;
                push_sel     = PW_CCR;
                state_d      = S_VECTOR;
            end
            S_VECTOR: begin
                // Fetch of the stale PC is discarded as the vector loads.
                seq_bubble_o   = 1'b1;
                seq_flush_fd_o = 1'b1;
                int_load_pc_o  = 1'b1;
                int_ack_o      = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Push-word mux over the saved context.
    always_comb begin
        push_data_o = '0;
        unique case (push_sel)
            PW_PC_HI: push_data_o = DATA_W'(pc_q[ADDR_W-1:DATA_W]);
            PW_PC_LO: push_data_o = pc_q[DATA_W-1:0];
            PW_CCR:   push_data_o = DATA_W'(ccr_q);
            default:  push_data_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central pipeline controller: forwarding, load-use stall,
// branch flush and interrupt sequencing.
module pipe_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 32,
    parameter int                REG_AW       = 3,
    parameter int                CCR_W        = 3,
    parameter int                DRAIN_CYCLES = 3,
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR = '0
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic              int_req,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_uses_rs,
    input  logic              dec_uses_rd,
    input  logic [ADDR_W-1:0] dec_pc,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [CCR_W-1:0]  ccr_in,
    output logic [1:0]        fwd_src_sel,
    output logic [1:0]        fwd_dst_sel,
    output logic              pc_hold,
    output logic              fd_enable,
    output logic              cu_bubble,
    output logic              flush_fd,
    output logic              flush_de,
    output logic              int_push,
    output logic [DATA_W-1:0] push_data,
    output logic              int_load_pc,
    output logic [ADDR_W-1:0] pc_vector,
    output logic              int_active,
    output logic              int_ack
);

    logic seq_hold, seq_bubble, seq_flush_fd;
    logic load_use, stall;

    int_sequencer #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .CCR_W        (CCR_W),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_seq (
        .clk            (clk),
        .RESET_n        (RESET_n),
        .int_req_i      (int_req),
        .dec_pc_i       (dec_pc),
        .br_taken_i     (ex_branch_taken),
        .br_target_i    (ex_branch_target),
        .ccr_i          (ccr_in),
        .seq_hold_o     (seq_hold),
        .seq_bubble_o   (seq_bubble),
        .seq_flush_fd_o (seq_flush_fd),
        .int_push_o     (int_push),
        .push_data_o    (push_data),
        .int_load_pc_o  (int_load_pc),
        .int_ack_o      (int_ack),
        .int_active_o   (int_active)
    );

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] idx);
        if (mem_reg_write && mem_rd == idx) return FWD_MEM;
        if (wb_reg_write && wb_rd == idx)   return FWD_WB;
        return FWD_REG;
    endfunction

    assign pc_vector = INT_VEC_ADDR;

    // Operand forwarding; memory stage wins over writeback.
    always_comb begin
        fwd_src_sel = fwd_sel(ex_rs);
        fwd_dst_sel = fwd_sel(ex_rd);
    end

    // Load-use stall, branch flush and sequencer override merge.
    always_comb begin
        load_use = ex_mem_read && !int_active &&
                   ((dec_uses_rs && dec_rs == ex_rd) ||
                    (dec_uses_rd && dec_rd == ex_rd));
        stall     = load_use && !ex_branch_taken;
        pc_hold   = seq_hold | stall;
        fd_enable = ~(seq_hold | stall);
        cu_bubble = seq_bubble | stall;
        flush_fd  = ex_branch_taken | seq_flush_fd;
        flush_de  = ex_branch_taken;
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit.
// Each scenario task drives vectors and checks inline.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        RESET_n = 1'b1;
    logic        int_req;
    logic [2:0]  dec_rs, dec_rd, ex_rs, ex_rd, mem_rd, wb_rd;
    logic        dec_uses_rs, dec_uses_rd;
    logic [31:0] dec_pc, ex_branch_target;
    logic        ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, wb_reg_write;
    logic [2:0]  ccr_in;
    logic [1:0]  fwd_src_sel, fwd_dst_sel;
    logic        pc_hold, fd_enable, cu_bubble, flush_fd, flush_de;
    logic        int_push, int_load_pc, int_active, int_ack;
    logic [15:0] push_data;
    logic [31:0] pc_vector;

    int vectors = 0;
    int miscompares = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .RESET_n(RESET_n), .int_req(int_req),
        .dec_rs(dec_rs), .dec_rd(dec_rd),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rd(dec_uses_rd),
        .dec_pc(dec_pc), .ex_rs(ex_rs), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .ccr_in(ccr_in),
        .fwd_src_sel(fwd_src_sel), .fwd_dst_sel(fwd_dst_sel),
        .pc_hold(pc_hold), .fd_enable(fd_enable), .cu_bubble(cu_bubble),
        .flush_fd(flush_fd), .flush_de(flush_de), .int_push(int_push),
        .push_data(push_data), .int_load_pc(int_load_pc),
        .pc_vector(pc_vector), .int_active(int_active), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        int_req = 0; dec_rs = 0; dec_rd = 0; ex_rs = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0; dec_uses_rs = 0; dec_uses_rd = 0;
        dec_pc = 0; ex_branch_target = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0;
        ccr_in = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 RESET_n = 0;
        #1;
        vectors++;
        if ({fd_enable, pc_hold, cu_bubble, flush_fd, flush_de} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 10000",
                     {fd_enable, pc_hold, cu_bubble, flush_fd, flush_de});
        end
        vectors++;
        if ({int_push, int_load_pc, int_active, int_ack, push_data} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_seq got %h want 0",
                     {int_push, int_load_pc, int_active, int_ack, push_data});
        end
        vectors++;
        if ({fwd_src_sel, fwd_dst_sel} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_fwd got %b want 0000", {fwd_src_sel, fwd_dst_sel});
        end
        step(); step();
        RESET_n = 1;
        step();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        ex_rs = 3; mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
        #1;
        vectors++;
        if (fwd_src_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL fwd_mem_prio got %0d want 1", fwd_src_sel);
        end
        mem_reg_write = 0;
        #1;
        vectors++;
        if (fwd_src_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL fwd_wb got %0d want 2", fwd_src_sel);
        end
        ex_rd = 6; wb_rd = 6; mem_rd = 6; mem_reg_write = 0; wb_reg_write = 1;
        #1;
        vectors++;
        if ({fwd_src_sel, fwd_dst_sel} !== {2'd0, 2'd2}) begin
            miscompares++;
            $display("FAIL fwd_dst_wb got %b want 0010", {fwd_src_sel, fwd_dst_sel});
        end
        mem_reg_write = 1;
        #1;
        vectors++;
        if (fwd_dst_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL fwd_dst_mem got %0d want 1", fwd_dst_sel);
        end
        wb_reg_write = 0; mem_reg_write = 0;
        #1;
        vectors++;
        if ({fwd_src_sel, fwd_dst_sel} !== 4'b0) begin
            miscompares++;
            $display("FAIL fwd_none got %b want 0000", {fwd_src_sel, fwd_dst_sel});
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_mem_read = 1; ex_rd = 5; dec_rs = 5; dec_uses_rs = 1;
        #1;
        vectors++;
        if ({pc_hold, fd_enable, cu_bubble} !== 3'b101) begin
            miscompares++;
            $display("FAIL stall_rs got %b want 101", {pc_hold, fd_enable, cu_bubble});
        end
        ex_branch_taken = 1;
        #1;
        vectors++;
        if ({flush_fd, flush_de, pc_hold, cu_bubble, fd_enable} !== 5'b11001) begin
            miscompares++;
            $display("FAIL branch_over_stall got %b want 11001",
                     {flush_fd, flush_de, pc_hold, cu_bubble, fd_enable});
        end
        ex_branch_taken = 0; dec_uses_rs = 0; dec_rd = 5; dec_uses_rd = 1;
        #1;
        vectors++;
        if ({pc_hold, fd_enable, cu_bubble} !== 3'b101) begin
            miscompares++;
            $display("FAIL stall_rd got %b want 101", {pc_hold, fd_enable, cu_bubble});
        end
        ex_mem_read = 0;
        #1;
        vectors++;
        if ({pc_hold, fd_enable, cu_bubble} !== 3'b010) begin
            miscompares++;
            $display("FAIL no_load_no_stall got %b want 010",
                     {pc_hold, fd_enable, cu_bubble});
        end
        clear_inputs();
        step();
    endtask

    task automatic test_int_basic();
        clear_inputs();
        dec_pc = 32'h0001_2345; ccr_in = 3'b010;
        step();
        int_req = 1;
        #1;
        vectors++;
        if ({flush_fd, int_active} !== 2'b10) begin
            miscompares++;
            $display("FAIL int_entry got %b want 10", {flush_fd, int_active});
        end
        step();
        dec_pc = 32'hDEAD_0000;
        #1;
        vectors++;
        if ({int_active, pc_hold, fd_enable, cu_bubble, int_push} !== 5'b11010) begin
            miscompares++;
            $display("FAIL drain1 got %b want 11010",
                     {int_active, pc_hold, fd_enable, cu_bubble, int_push});
        end
        step(); int_req = 0;
        step(); ccr_in = 3'b101;
        #1;
        vectors++;
        if (int_push !== 1'b0) begin
            miscompares++;
            $display("FAIL drain3_nopush got %b want 0", int_push);
        end
        step(); ccr_in = 3'b111;
        #1;
        vectors++;
        if ({int_push, push_data} !== {1'b1, 16'h0001}) begin
            miscompares++;
            $display("FAIL push_hi got %b/%h want 1/0001", int_push, push_data);
        end
        step(); #1;
        vectors++;
        if ({int_push, push_data} !== {1'b1, 16'h2345}) begin
            miscompares++;
            $display("FAIL push_lo got %b/%h want 1/2345", int_push, push_data);
        end
        step(); #1;
        vectors++;
        if ({int_push, push_data, pc_hold} !== {1'b1, 16'h0005, 1'b1}) begin
            miscompares++;
            $display("FAIL push_ccr got %b/%h/%b want 1/0005/1",
                     int_push, push_data, pc_hold);
        end
        step(); #1;
        vectors++;
        if ({int_load_pc, int_ack, pc_hold, int_push, pc_vector} !==
            {4'b1100, 32'h0}) begin
            miscompares++;
            $display("FAIL vector got %b%b%b%b/%h want 1100/00000000",
                     int_load_pc, int_ack, pc_hold, int_push, pc_vector);
        end
        step(); #1;
        vectors++;
        if ({int_active, int_ack, int_load_pc} !== 3'b000) begin
            miscompares++;
            $display("FAIL back_idle got %b want 000",
                     {int_active, int_ack, int_load_pc});
        end
    endtask

    task automatic test_int_branch();
        clear_inputs();
        dec_pc = 32'h0001_2345; ccr_in = 3'b011;
        step();
        int_req = 1;
        step();
        step();
        ex_branch_taken = 1; ex_branch_target = 32'h0000_0040;
        #1;
        vectors++;
        if ({flush_fd, flush_de, pc_hold} !== 3'b111) begin
            miscompares++;
            $display("FAIL drain_branch got %b want 111", {flush_fd, flush_de, pc_hold});
        end
        step(); ex_branch_taken = 0; int_req = 0;
        step(); #1;
        vectors++;
        if ({int_push, push_data} !== {1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL br_push_hi got %b/%h want 1/0000", int_push, push_data);
        end
        step(); #1;
        vectors++;
        if ({int_push, push_data} !== {1'b1, 16'h0040}) begin
            miscompares++;
            $display("FAIL br_push_lo got %b/%h want 1/0040", int_push, push_data);
        end
        step(); step(); step(); #1;
        vectors++;
        if (int_active !== 1'b0) begin
            miscompares++;
            $display("FAIL br_idle got %b want 0", int_active);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        dec_pc = 32'h0000_1111;
        step();
        int_req = 1;
        step();
        step(); int_req = 0;
        step();
        step();
        step(); int_req = 1;
        #1;
        vectors++;
        if ({int_push, push_data} !== {1'b1, 16'h1111}) begin
            miscompares++;
            $display("FAIL b2b_push_lo got %b/%h want 1/1111", int_push, push_data);
        end
        step(); #1;
        vectors++;
        if (int_push !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_push_ccr got %b want 1", int_push);
        end
        step(); #1;
        vectors++;
        if ({int_load_pc, int_ack} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_vector got %b want 11", {int_load_pc, int_ack});
        end
        step(); #1;
        vectors++;
        if ({int_active, flush_fd} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_idle_gap got %b want 01", {int_active, flush_fd});
        end
        step(); int_req = 0;
        #1;
        vectors++;
        if ({int_active, pc_hold} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_redrain got %b want 11", {int_active, pc_hold});
        end
        for (int i = 0; i < 7; i++) step();
        #1;
        vectors++;
        if (int_active !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_final_idle got %b want 0", int_active);
        end
    endtask

    task automatic test_reset_mid();
        int pushes;
        clear_inputs();
        dec_pc = 32'h0002_0002;
        step();
        int_req = 1;
        step();
        step(); int_req = 0;
        step();
        step(); #1;
        vectors++;
        if (int_push !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_push got %b want 1", int_push);
        end
        RESET_n = 0;
        #1;
        vectors++;
        if ({int_push, int_active, push_data} !== 18'h0) begin
            miscompares++;
            $display("FAIL rst_mid got %b%b/%h want 00/0000",
                     int_push, int_active, push_data);
        end
        step(); step();
        RESET_n = 1;
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (int_push || int_active) pushes++;
        end
        vectors++;
        if (pushes !== 0) begin
            miscompares++;
            $display("FAIL rst_no_repush got %0d active cycles want 0", pushes);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_int_basic();
        test_int_branch();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Centralised pipeline controller for the five-stage core; replaces the separate hazard-detection and forwarding blocks.
- Parametrised in data, address and register-index width.
- Adds behaviour the current core lacks: taken-branch flush, and an interrupt sequencer.
- The sequencer drains the pipe, pushes the return PC and CCR through the memory-stage push path, then redirects fetch to a vector.

Parameters:
DATA_W, 16, datapath/stack word width
ADDR_W, 32, PC width; must satisfy DATA_W < ADDR_W <= 2*DATA_W
REG_AW, 3, register index width
CCR_W, 3, flag register width
DRAIN_CYCLES, 3, bubble cycles so in-flight instructions retire before pushing
INT_VEC_ADDR, 0, interrupt vector PC

Ports:
clk  in  1  clock, rising edge
RESET_n  in  1  asynchronous, active-low reset
int_req  in  1  external interrupt request, rising-edge sensitive
dec_rs, dec_rd  in  REG_AW each  decode-stage operand indices
dec_uses_rs, dec_uses_rd  in  1 each  decode instruction reads that operand
dec_pc  in  ADDR_W  address of the instruction in decode
ex_rs, ex_rd  in  REG_AW each  execute-stage indices
ex_mem_read  in  1  execute instruction is a load/pop
ex_branch_taken  in  1  execute resolves a taken branch
ex_branch_target  in  ADDR_W  target of that branch
mem_rd  in  REG_AW  memory-stage destination
mem_reg_write  in  1  memory-stage writeback enable
wb_rd  in  REG_AW  writeback-stage destination
wb_reg_write  in  1  writeback enable
ccr_in  in  CCR_W  current flags
fwd_src_sel, fwd_dst_sel  out  2 each  forwarding mux selects
pc_hold  out  1  freeze PC
fd_enable  out  1  fetch/decode register enable
cu_bubble  out  1  force NOP control word into decode/execute register
flush_fd, flush_de  out  1 each  clear fetch/decode, decode/execute registers
int_push  out  1  push request to memory stage
push_data  out  DATA_W  word to push
int_load_pc  out  1  load pc_vector into PC
pc_vector  out  ADDR_W  = INT_VEC_ADDR
int_active  out  1  sequencer not IDLE
int_ack  out  1  one-cycle pulse on vector load

Behaviour:
- Reset (async, RESET_n=0):
  - State IDLE; edge register and pending flag cleared; saved PC and CCR zero.
  - Outputs: fd_enable=1; all other control outputs 0; selects 0; push_data 0.
- Forwarding (combinational), for each of ex_rs -> fwd_src_sel and ex_rd -> fwd_dst_sel:
  - 1 if mem_reg_write and mem_rd matches.
  - Else 2 if wb_reg_write and wb_rd matches.
  - Else 0. Memory stage has priority.
- Load-use stall (combinational, IDLE only):
  - Condition: ex_mem_read and ((dec_uses_rs and dec_rs==ex_rd) or (dec_uses_rd and dec_rd==ex_rd)).
  - Response: pc_hold=1, fd_enable=0, cu_bubble=1.
- Branch flush:
  - ex_branch_taken -> flush_fd=1, flush_de=1 in the same cycle.
  - Overrides a stall in that cycle (no pc_hold, no cu_bubble).
- Interrupt edge: int_req_q registered each cycle; edge = int_req & ~int_req_q.
  - An edge while not IDLE sets pending; pending is served on return to IDLE.
- FSM states: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_CCR, VECTOR.
  - IDLE -> DRAIN on (edge or pending):
    - Capture saved_pc=dec_pc, or ex_branch_target if ex_branch_taken that cycle; clear pending.
    - The decode instruction is squashed (flush_fd=1) and re-executed after return.
  - DRAIN: pc_hold=1, fd_enable=0, cu_bubble=1 for DRAIN_CYCLES cycles (down-counter), then PUSH_HI.
    - ex_branch_taken during DRAIN overwrites saved_pc with ex_branch_target.
    - ccr_in is captured on the last DRAIN cycle.
  - PUSH_HI: int_push=1, push_data = saved_pc upper bits, zero-extended to DATA_W.
  - PUSH_LO: int_push=1, push_data = saved_pc[DATA_W-1:0].
  - PUSH_CCR: int_push=1, push_data = saved CCR, zero-extended.
  - VECTOR: int_load_pc=1, int_ack=1, pc_hold=0 -> IDLE.
  - Stall outputs stay asserted through all PUSH states.
- Latency: interrupt edge at cycle N -> int_load_pc at cycle N+DRAIN_CYCLES+4.
- Reset mid-sequence: immediate return to IDLE; no partial push is re-issued.

Decomposition:
- Shared package pipe_pkg:
  - State encoding.
  - Forward select constants FWD_REG=0, FWD_MEM=1, FWD_WB=2.
  - Push-word select codes.
- One sub-module, int_sequencer: FSM, drain counter, edge/pending logic, saved PC/CCR.
- Forwarding and stall logic stay in the top level.

Test Plan:
- ex_rs=3, mem_rd=3 mem_reg_write=1, wb_rd=3 wb_reg_write=1 -> fwd_src_sel=1; then mem_reg_write=0 -> 2.
- ex_mem_read=1 ex_rd=5, dec_rs=5 dec_uses_rs=1 -> pc_hold=1 fd_enable=0 cu_bubble=1; same with ex_branch_taken=1 -> flush_fd=flush_de=1, pc_hold=0.
- dec_pc=0x00012345, ccr_in=3'b101, int_req rises -> after 3 drain cycles pushes 0x0001, 0x2345, 0x0005 on consecutive cycles; int_load_pc and int_ack at edge+7; pc_vector=0.
- ex_branch_taken=1 with target 0x40 in second DRAIN cycle -> pushed words 0x0000, 0x0040.
- Second int_req edge during PUSH_LO -> sequence completes; IDLE for one cycle; new DRAIN begins the next cycle.
- RESET_n low during PUSH_HI -> int_push=0, int_active=0 immediately; after release, no push without a new edge.
